// File: rtl/fifo_data_buffer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_data_buffer_pkg
// Shared types and constants for the RMII TX byte-to-dibit buffer.
//   dibit_t         : 2-bit RMII symbol
//   byte_t          : byte-wide FIFO payload
//   DIBITS_PER_BYTE : symbols emitted per byte
//   ser_state_t     : serializer FSM states
// -----------------------------------------------------------------------------
package fifo_data_buffer_pkg;

    typedef logic [1:0] dibit_t;
    typedef logic [7:0] byte_t;

    localparam int unsigned DIBITS_PER_BYTE = 4;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } ser_state_t;

endpackage : fifo_data_buffer_pkg

// File: rtl/fifo_data_buffer_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Generic synchronous byte FIFO with first-word-fall-through read data.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset (pointers and count only)
//   push  : write request; dropped when full unless a pop happens this cycle
//   pop   : read request; ignored when empty
//   din   : write data
//   dout  : head-of-queue data (valid when !empty)
//   full  : count == DEPTH
//   empty : count == 0
//   count : occupancy, clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module byte_fifo
    import fifo_data_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    byte_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule : byte_fifo

// File: rtl/fifo_data_buffer.sv
// -----------------------------------------------------------------------------
// fifo_data_buffer
// RMII TX byte-to-dibit buffer: bytes queued one per clock, drained as a
// continuous stream of 2-bit symbols, LSB dibit first, 4 clocks per byte.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   valid_in : byte_in valid / write request
//   byte_in  : byte to enqueue
//   axiov    : axiod valid (registered)
//   axiod    : current dibit (registered, 0 when axiov is 0)
// Optional (macro FIFO_DATA_BUFFER_STATUS_EN):
//   full     : FIFO holds DEPTH bytes
//   empty    : FIFO holds no bytes
//   overflow : sticky, set when a write is dropped; cleared only by reset
// Parameter DEPTH: FIFO capacity in bytes, power of two, >= 4.
// -----------------------------------------------------------------------------
module fifo_data_buffer
    import fifo_data_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [7:0] byte_in,
    output logic       axiov,
    output logic [1:0] axiod
`ifdef FIFO_DATA_BUFFER_STATUS_EN
    ,
    output logic       full,
    output logic       empty,
    output logic       overflow
`endif
);

    localparam logic [1:0] LAST_IDX = 2'(DIBITS_PER_BYTE - 1);

    ser_state_t             state, state_n;
    logic [1:0]             idx, idx_n;
    byte_t                  shreg, shreg_n;
    logic                   load;
    logic                   axiov_n;
    dibit_t                 axiod_n;

    byte_t                  fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid_in),
        .pop   (load),
        .din   (byte_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register; outputs are registered here as well.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            shreg <= '0;
            axiov <= 1'b0;
            axiod <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            axiov <= axiov_n;
            axiod <= axiod_n;
        end
    end

    // Next state: a new byte loads whenever the serializer is idle or on its
    // last dibit, which gives gapless back-to-back bytes.
    always_comb begin
        load    = ((state == ST_IDLE) || (idx == LAST_IDX)) && !fifo_empty;
        state_n = state;
        idx_n   = idx;
        shreg_n = shreg;
        if (load) begin
            state_n = ST_SEND;
            idx_n   = '0;
            shreg_n = fifo_dout;
        end else if (state == ST_SEND) begin
            shreg_n = shreg >> 2;
            if (idx == LAST_IDX) begin
                state_n = ST_IDLE;
                idx_n   = '0;
            end else begin
                idx_n   = idx + 2'd1;
            end
        end
    end

    // Output decode: the load edge emits bits [1:0] straight from the FIFO
    // head; later edges take the next dibit from the shifted copy.
    always_comb begin
        axiov_n = 1'b0;
        axiod_n = '0;
        if (load) begin
            axiov_n = 1'b1;
            axiod_n = fifo_dout[1:0];
        end else if ((state == ST_SEND) && (idx != LAST_IDX)) begin
            axiov_n = 1'b1;
            axiod_n = shreg[3:2];
        end
    end

`ifdef FIFO_DATA_BUFFER_STATUS_EN
    assign full  = fifo_full;
    assign empty = fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (valid_in && fifo_full && !load) begin
            overflow <= 1'b1;
        end
    end
`else
    logic unused_status;
    assign unused_status = ^{fifo_full, fifo_count};
`endif

endmodule : fifo_data_buffer

// File: tb/tb_fifo_data_buffer.sv
// -----------------------------------------------------------------------------
// tb_fifo_data_buffer
// Directed bench for fifo_data_buffer (DEPTH=4). Expected dibits are queued
// when a byte that should be accepted is driven and popped by the monitor.
// Status ports are checked when FIFO_DATA_BUFFER_STATUS_EN is defined.
// -----------------------------------------------------------------------------
module tb_fifo_data_buffer;

    localparam int unsigned DEPTH = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] byte_in  = '0;
    logic       axiov;
    logic [1:0] axiod;
`ifdef FIFO_DATA_BUFFER_STATUS_EN
    logic       full;
    logic       empty;
    logic       overflow;
`endif

    int         checks   = 0;
    int         errors   = 0;
    logic [1:0] exp_q[$];
    int         run_len  = 0;
    int         last_run = 0;

    fifo_data_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .byte_in  (byte_in),
        .axiov    (axiov),
        .axiod    (axiod)
`ifdef FIFO_DATA_BUFFER_STATUS_EN
        ,
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: compares every valid dibit with the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            check("reset_axiov", {31'd0, axiov}, 32'd0);
            check("reset_axiod", {30'd0, axiod}, 32'd0);
            run_len = 0;
        end else if (axiov === 1'b1) begin
            run_len++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {31'd0, axiov}, 32'd0);
            end else begin
                check("dibit", {30'd0, axiod}, {30'd0, exp_q.pop_front()});
            end
        end else begin
            check("idle_axiov", {31'd0, axiov}, 32'd0);
            check("idle_axiod", {30'd0, axiod}, 32'd0);
            if (run_len > 0) last_run = run_len;
            run_len = 0;
        end
    end

    task automatic write_byte(input logic [7:0] b, input bit accept);
        valid_in = 1'b1;
        byte_in  = b;
        if (accept) begin
            exp_q.push_back(b[1:0]);
            exp_q.push_back(b[3:2]);
            exp_q.push_back(b[5:4]);
            exp_q.push_back(b[7:6]);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        valid_in = 1'b0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_drained"}, exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check({tag, "_idle_after"}, {31'd0, axiov}, 32'd0);
    endtask

    initial begin
        // Reset held with valid_in toggling.
        rst = 1'b0;
        repeat (6) begin
            valid_in = ~valid_in;
            byte_in  = 8'($urandom);
            @(negedge clk);
        end
        check("reset_hold_axiov", {31'd0, axiov}, 32'd0);
        valid_in = 1'b0;
        rst      = 1'b1;
        idle(6);
        check("post_reset_axiov", {31'd0, axiov}, 32'd0);
`ifdef FIFO_DATA_BUFFER_STATUS_EN
        check("post_reset_empty", {31'd0, empty}, 32'd1);
        check("post_reset_overflow", {31'd0, overflow}, 32'd0);
`endif

        // Single byte: 2,0,1,3.
        last_run = 0;
        write_byte(8'hD2, 1'b1);
        drain("single");
        check("single_run_len", last_run, 32'd4);

        // Burst: 4 x D2, one idle cycle, 2 x C5 -> 24 gapless dibits.
        last_run = 0;
        repeat (4) write_byte(8'hD2, 1'b1);
        idle(1);
        repeat (2) write_byte(8'hC5, 1'b1);
        drain("burst");
        check("burst_run_len", last_run, 32'd24);

        // Overflow: 8 consecutive writes into DEPTH=4. Bytes 0..4 fit (one pop
        // happens after the first), byte 5 lands on a pop while full, 6..7 drop.
        last_run = 0;
        for (int i = 0; i < 8; i++) begin
            write_byte(8'h10 + 8'(i * 8'h1B), i < 6);
`ifdef FIFO_DATA_BUFFER_STATUS_EN
            if (i == 4) check("ovf_full", {31'd0, full}, 32'd1);
`endif
        end
        drain("overflow");
        check("overflow_run_len", last_run, 32'd24);
`ifdef FIFO_DATA_BUFFER_STATUS_EN
        check("overflow_sticky", {31'd0, overflow}, 32'd1);
        check("overflow_empty", {31'd0, empty}, 32'd1);
`endif

        // Reset mid-stream during dibit index 2 of the first of three bytes.
        write_byte(8'hA1, 1'b1);
        write_byte(8'hB2, 1'b1);
        write_byte(8'hC3, 1'b1);
        idle(1);
        check("mid_valid_before_reset", {31'd0, axiov}, 32'd1);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_axiov", {31'd0, axiov}, 32'd0);
        check("async_reset_axiod", {30'd0, axiod}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(10);
        check("no_stale_after_reset", {31'd0, axiov}, 32'd0);
`ifdef FIFO_DATA_BUFFER_STATUS_EN
        check("reset_clears_overflow", {31'd0, overflow}, 32'd0);
`endif
        last_run = 0;
        write_byte(8'h5A, 1'b1);
        drain("post_reset");
        check("post_reset_run_len", last_run, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_data_buffer

// File: doc/fifo_data_buffer.md
Name: fifo_data_buffer

Overview:
- Byte-to-dibit transmit buffer for the Ethernet RMII TX path.
- Accepts one byte per clock while valid_in is high and stores it in an internal FIFO.
- Drains the FIFO as a continuous stream of 2-bit symbols (axiod/axiov), 4 clocks per byte, LSB dibit first.
- Sits between the byte-wide packet builder and the RMII TX pins.

Parameters:
- DEPTH, 64, FIFO capacity in bytes; must be a power of two, at least 4.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- valid_in  input  1  byte_in is valid this cycle; write request.
- byte_in  input  8  byte to enqueue.
- axiov  output  1  axiod is valid this cycle.
- axiod  output  2  current output dibit.

Behaviour:
- Reset (rst=0, asynchronous): immediately clear write/read pointers, count, shift register and dibit counter; axiov=0, axiod=2'b00. Memory contents are not cleared.
- Reset asserted mid-stream aborts the byte in flight; no partial dibits appear after release.
- Write: on a rising edge with valid_in=1, byte_in is stored at wr_ptr and wr_ptr increments modulo DEPTH.
- Full: count==DEPTH with no pop in the same cycle drops the write silently.
- Full with a pop in the same cycle: the write is accepted.
- Pointer and count widths: pointers are clog2(DEPTH) bits and wrap naturally; count is clog2(DEPTH)+1 bits.
- Serializer states:
  - IDLE: axiov=0, axiod=0.
  - SEND: dibit index 0..3.
- Pop/load rule: on a rising edge where (state==IDLE or dibit index==3) and count>0, pop the head byte into the shift register.
  - That edge sets axiov=1, axiod=byte[1:0], index=0.
- Subsequent edges in SEND output byte[3:2], [5:4], [7:6] in order, with index 1, 2, 3.
- Continuity: if the FIFO is non-empty at index 3, the next byte loads with no gap. If it is empty at index 3, the next edge enters IDLE and drives axiov=0, axiod=0.
- Latency: a byte written into an empty, idle buffer at edge N appears as dibit 0 at edge N+1. There is no combinational bypass.
- Simultaneous write and pop: both take effect and count is unchanged.
- Outputs are registered; axiod is 0 whenever axiov is 0.
- Byte order is FIFO order; there is no reordering or duplication.

Optional Feature:
- Macro: FIFO_DATA_BUFFER_STATUS_EN.
- Defined: adds three output ports.
  - full (1 bit): count==DEPTH.
  - empty (1 bit): count==0.
  - overflow (1 bit): sticky; set when a write is dropped, cleared only by reset.
- Not defined: those ports and the sticky overflow register do not exist. Core behaviour is identical in both cases.

Decomposition:
- Package fifo_data_buffer_pkg:
  - typedef dibit_t (logic [1:0]);
  - typedef byte_t (logic [7:0]);
  - localparam DIBITS_PER_BYTE=4.
- Sub-module byte_fifo: a generic synchronous FIFO with push/pop/full/empty/count, parameterised by DEPTH.
- Serializer FSM and shift register live in fifo_data_buffer.

Test Plan:
- Reset: hold rst=0 with valid_in toggling -> axiov=0, axiod=0 throughout. Release rst -> outputs stay 0 until the first write.
- Single byte: write 8'hD2 for one cycle -> next 4 cycles axiov=1 with axiod=2,0,1,3, then axiov=0.
- Back-to-back burst: 4 cycles of 8'hD2, idle, then 2 cycles of 8'hC5. Required response:
  - exactly 24 consecutive axiov=1 cycles with no gap;
  - dibit pattern 2,0,1,3 four times, then 1,1,0,3 twice;
  - axiov=0 afterwards.
- Overflow: DEPTH=4, write 8 distinct bytes consecutively. Required response:
  - only the first bytes accepted while space remains are serialized, in order; the rest are dropped;
  - with FIFO_DATA_BUFFER_STATUS_EN defined, overflow=1.
- Full plus pop: fill to DEPTH, then write on the exact cycle of a pop -> the byte is accepted and appears last in the output.
- Reset mid-stream: assert rst during dibit index 2 -> axiov drops to 0 asynchronously. After release, no stale bytes are emitted.
